// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module   : score_display
// Purpose  : Resynchronises a 4-digit BCD score, snapshots it once per scan
//            frame and time-multiplexes it onto the Basys3 seven-segment pins.
//            Optional macro LEADING_ZERO_BLANK_EN darkens leading-zero digits.
// Revision : 1.0 - initial release
// ============================================================================
module score_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thous,
    input  logic       blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int                  PCNT_W    = $clog2(REFRESH_DIV);
    localparam logic [PCNT_W-1:0]   PCNT_LAST = PCNT_W'(REFRESH_DIV - 1);

    logic [15:0]       s1_q, s1_d;
    logic [15:0]       s2_q, s2_d;
    logic [15:0]       stable_q, stable_d;
    logic [15:0]       frame_q, frame_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              w_tick;
    logic              w_lead_zero;
    logic [3:0]        w_digit;

    // Active-low {g,f,e,d,c,b,a}; anything above 9 shows a dash as a fault flag.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        case (idx_q)
            2'd3:    w_lead_zero = (frame_q[15:12] == 4'd0);
            2'd2:    w_lead_zero = (frame_q[15:8]  == 8'd0);
            2'd1:    w_lead_zero = (frame_q[15:4]  == 12'd0);
            default: w_lead_zero = 1'b0;
        endcase
    end
`else
    assign w_lead_zero = 1'b0;
`endif

    always_comb begin
        s1_d     = {thous, hundreds, tens, ones};
        s2_d     = s1_q;
        // Only accept a value seen identically on two consecutive edges.
        stable_d = (s1_q == s2_q) ? s2_q : stable_q;

        w_tick   = (pcnt_q == PCNT_LAST);
        pcnt_d   = w_tick ? '0 : pcnt_q + 1'b1;
        idx_d    = w_tick ? idx_q + 2'd1 : idx_q;
        frame_d  = (w_tick && idx_q == 2'd3) ? stable_q : frame_q;

        // Next-state frame/index: on a tick this is already the new slot's digit.
        w_digit  = frame_d[{idx_d, 2'b00} +: 4];
        seg_d    = seg_decode(w_digit);

        an_d     = 4'hF;
        if (!w_tick && !blank && !w_lead_zero) begin
            an_d = ~(4'b0001 << idx_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            frame_q  <= '0;
            pcnt_q   <= '0;
            idx_q    <= '0;
            an_q     <= 4'hF;
            seg_q    <= 7'h7F;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            frame_q  <= frame_d;
            pcnt_q   <= pcnt_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_score_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_display
// Purpose  : Self-checking bench for score_display against an edge-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_display;

    localparam int DIV = 4;
    localparam int HMAX = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ones = 4'd0, tens = 4'd0, hundreds = 4'd0, thous = 4'd0;
    logic       blank = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int total = 0;
    int bad   = 0;

    int          e;
    logic [15:0] hist  [0:HMAX-1];
    logic        bhist [0:HMAX-1];
    logic [6:0]  seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    score_display #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst),
        .ones(ones), .tens(tens), .hundreds(hundreds), .thous(thous),
        .blank(blank), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    // Edge counter since reset release, plus the input seen at each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e <= 0;
        end else if (e < HMAX - 1) begin
            hist[e+1]  <= {thous, hundreds, tens, ones};
            bhist[e+1] <= blank;
            e          <= e + 1;
        end
    end

    function automatic logic [15:0] h(input int k);
        return (k <= 0) ? 16'h0000 : hist[k];
    endfunction

    // Latest value that appeared on two consecutive captures, as of edge ev.
    function automatic logic [15:0] stable_after(input int ev);
        for (int m = ev; m >= 1; m--) begin
            if (h(m-1) == h(m-2)) return h(m-2);
        end
        return 16'h0000;
    endfunction

    function automatic logic [6:0] dec(input logic [3:0] d);
        return (d > 4'd9) ? 7'h3F : seg_tab[d];
    endfunction

    task automatic model(input int ev, output logic [3:0] ean, output logic [6:0] eseg);
        int          idx;
        int          fstart;
        logic [15:0] fr;
        logic        lit;
        if (ev == 0) begin
            ean  = 4'hF;
            eseg = 7'h7F;
        end else begin
            idx    = (ev / DIV) % 4;
            fstart = (ev / (4 * DIV)) * 4 * DIV;
            fr     = (fstart == 0) ? 16'h0000 : stable_after(fstart - 1);
            eseg   = dec(fr[idx*4 +: 4]);
            lit    = (ev % DIV != 0) && !bhist[ev];
`ifdef LEADING_ZERO_BLANK_EN
            if (idx > 0 && (fr >> (4 * idx)) == 16'h0000) lit = 1'b0;
`endif
            ean = lit ? ~(4'b0001 << idx) : 4'hF;
        end
    endtask

    task automatic check_now();
        logic [3:0] ean;
        logic [6:0] eseg;
        model(e, ean, eseg);
        total++;
        assert (an === ean) else begin
            bad++;
            $error("FAIL an e=%0d got=%h want=%h", e, an, ean);
        end
        total++;
        assert (seg === eseg) else begin
            bad++;
            $error("FAIL seg e=%0d got=%h want=%h", e, seg, eseg);
        end
        total++;
        assert (dp === 1'b1) else begin
            bad++;
            $error("FAIL dp e=%0d got=%b want=1", e, dp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            check_now();
        end
    endtask

    task automatic set_val(input logic [15:0] v);
        {thous, hundreds, tens, ones} = v;
    endtask

    function automatic logic [3:0] rnd_digit();
        return ($urandom % 8 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    endfunction

    initial begin
        // Reset held: reset values on the pins.
        run(3);
        rst = 1'b0;
        run(40);

        set_val(16'h1234);
        run(40);

        // Change during the tens slot; rest of the frame keeps the old snapshot.
        for (int i = 0; i < 64 && ((e / DIV) % 4) != 1; i++) run(1);
        total++;
        assert (((e / DIV) % 4) == 1) else begin
            bad++;
            $error("FAIL tens_slot_wait got=%0d want=1", (e / DIV) % 4);
        end
        set_val(16'h5678);
        run(40);

        // Rapid toggling of ones, then hold.
        ones = 4'd3;
        for (int i = 0; i < 20; i++) begin
            run(1);
            ones = (ones == 4'd3) ? 4'd4 : 4'd3;
        end
        ones = 4'd4;
        run(3 + 4 * DIV + 2 + 20);

        // Invalid code, then blanking mid-slot.
        ones = 4'hB;
        run(36);
        for (int i = 0; i < 3 && (e % DIV) != 2; i++) run(1);
        blank = 1'b1;
        run(10);
        blank = 1'b0;
        run(20);

        set_val(16'h0105);
        run(36);
        set_val(16'h0000);
        run(36);
        set_val(16'h00A0);
        run(36);

        // Randomised values, hold times and blank pulses.
        for (int t = 0; t < 40; t++) begin
            set_val({rnd_digit(), rnd_digit(), rnd_digit(), rnd_digit()});
            if ($urandom % 6 == 0) begin
                set_val({4'd0, 4'd0, rnd_digit(), rnd_digit()});
            end
            blank = ($urandom % 10 == 0);
            run($urandom_range(1, 30));
        end
        blank = 1'b0;
        set_val(16'h9876);
        run(40);

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        assert (an === 4'hF && seg === 7'h7F) else begin
            bad++;
            $error("FAIL async_rst got=%h/%h want=f/7f", an, seg);
        end
        run(3);
        rst = 1'b0;
        run(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
